// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// Redirects reload the PC and flush the queue; decode stalls only back up into imem once the queue is full.
module fetch_queue_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               pcmux,
  input  logic [ADDR_W-1:0]        target_pc,
  input  logic [ADDR_W-1:0]        trap_pc,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_req,
  input  logic                     imem_r,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     br_stall,
  input  logic                     dep_stall,
  input  logic                     mem_stall,
  output logic                     de_v,
  output logic [INSTR_W-1:0]       de_ir,
  output logic [ADDR_W-1:0]        de_npc,
  output logic                     ld_de,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [INSTR_W-1:0] r_q_ir  [DEPTH];
  logic [ADDR_W-1:0]  r_q_npc [DEPTH];

  logic              w_redirect;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redirect_pc;

  assign w_redirect = (pcmux != 2'd0);
  assign w_full     = (r_count == FULL);
  assign w_empty    = (r_count == '0);
  assign w_pc_inc   = r_pc + PC_STEP;

  // Handshake: a fetch is accepted in any cycle where imem_req and imem_r are both high;
  // decode consumes the head in any cycle where de_v and ld_de are both high.
  assign ld_de    = !(dep_stall | mem_stall);
  assign imem_req = !reset & !w_redirect & !br_stall & !w_full;
  assign w_push   = imem_req & imem_r;
  assign de_v     = !reset & !w_empty & !br_stall & !w_redirect;
  assign w_pop    = de_v & ld_de;

  assign de_ir     = de_v ? r_q_ir[r_head]  : '0;
  assign de_npc    = de_v ? r_q_npc[r_head] : '0;
  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign q_count   = r_count;

  always_comb begin
    w_redirect_pc = r_pc;
    case (pcmux)
      2'd1:    w_redirect_pc = target_pc;
      2'd2:    w_redirect_pc = trap_pc;
      2'd3:    w_redirect_pc = RESET_PC;
      default: w_redirect_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_pc    <= w_redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= w_pc_inc;
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ir[r_tail]  <= instr;
      r_q_npc[r_tail] <= w_pc_inc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: cycle model with an expected-entry queue, a vector table,
// directed corner-case sequences and a constrained-random phase.
module tb_fetch_queue_stage;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam logic [AW-1:0] RESET_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    pcmux;
  logic [AW-1:0] target_pc;
  logic [AW-1:0] trap_pc;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_r;
  logic [IW-1:0] instr;
  logic          br_stall;
  logic          dep_stall;
  logic          mem_stall;
  logic          de_v;
  logic [IW-1:0] de_ir;
  logic [AW-1:0] de_npc;
  logic          ld_de;
  logic [AW-1:0] pc;
  logic [CW-1:0] q_count;

  always #5 clk = ~clk;

  // Instruction memory content: each word is the bitwise inverse of its address.
  assign instr = ~imem_addr;

  fetch_queue_stage #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .PC_INC(2), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .pcmux(pcmux), .target_pc(target_pc), .trap_pc(trap_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_r(imem_r), .instr(instr),
    .br_stall(br_stall), .dep_stall(dep_stall), .mem_stall(mem_stall),
    .de_v(de_v), .de_ir(de_ir), .de_npc(de_npc), .ld_de(ld_de),
    .pc(pc), .q_count(q_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0]    m_pc = RESET_PC;
  logic [AW+IW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [1:0] pm, input logic [AW-1:0] tgt, input logic [AW-1:0] trp,
                        input logic ir, input logic br, input logic dep, input logic mem);
    pcmux = pm; target_pc = tgt; trap_pc = trp;
    imem_r = ir; br_stall = br; dep_stall = dep; mem_stall = mem;
  endtask

  // Check every output against the model at the falling edge, then advance the model.
  task automatic tick();
    logic             m_redir;
    logic             m_req;
    logic             m_dev;
    logic             m_ld;
    logic [AW+IW-1:0] head;
    @(negedge clk);
    m_redir = (pcmux != 2'd0);
    m_ld    = !(dep_stall || mem_stall);
    m_req   = !reset && !m_redir && !br_stall && (exp_q.size() < D);
    m_dev   = !reset && (exp_q.size() != 0) && !br_stall && !m_redir;
    head    = m_dev ? exp_q[0] : '0;
    chk("pc",        32'(pc),        32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("imem_req",  32'(imem_req),  32'(m_req));
    chk("de_v",      32'(de_v),      32'(m_dev));
    chk("ld_de",     32'(ld_de),     32'(m_ld));
    chk("q_count",   32'(q_count),   32'(exp_q.size()));
    chk("de_npc",    32'(de_npc),    32'(head[AW+IW-1:IW]));
    chk("de_ir",     32'(de_ir),     32'(head[IW-1:0]));
    if (reset) begin
      m_pc = RESET_PC;
      exp_q.delete();
    end else if (m_redir) begin
      case (pcmux)
        2'd1:    m_pc = target_pc;
        2'd2:    m_pc = trap_pc;
        default: m_pc = RESET_PC;
      endcase
      exp_q.delete();
    end else begin
      if (m_dev && m_ld) void'(exp_q.pop_front());
      if (m_req && imem_r) begin
        exp_q.push_back({m_pc + 16'd2, ~m_pc});
        m_pc = m_pc + 16'd2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]    pcmux;
    logic [AW-1:0] tgt;
    logic [AW-1:0] trap;
    logic          ir;
    logic          br;
    logic          dep;
    logic          mem;
    logic          exp_ld;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
    vecs[1] = '{2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002};
    vecs[2] = '{2'd1, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100};
    vecs[3] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100};
    vecs[4] = '{2'd2, 16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200};
    vecs[5] = '{2'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002};
    vecs[7] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004};

    reset = 1'b1;
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_de_v",     32'(de_v),     32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Sequential fetch from reset: first entry visible the cycle after its accept.
    chk("seq_addr0", 32'(imem_addr), 32'h0000);
    chk("seq_dev0",  32'(de_v),      32'd0);
    tick();
    chk("seq_addr1", 32'(imem_addr), 32'h0002);
    chk("seq_dev1",  32'(de_v),      32'd1);
    chk("seq_ir1",   32'(de_ir),     32'hFFFF);
    chk("seq_npc1",  32'(de_npc),    32'h0002);
    tick();
    chk("seq_addr2", 32'(imem_addr), 32'h0004);
    tick();

    // Vector table, starting from a fresh reset-vector redirect.
    set_in(2'd3, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].pcmux, vecs[i].tgt, vecs[i].trap, vecs[i].ir, vecs[i].br, vecs[i].dep, vecs[i].mem);
      #1;
      chk($sformatf("vec%0d_ld_de", i), 32'(ld_de), 32'(vecs[i].exp_ld));
      tick();
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
    end

    // Decode stall fills the queue, then drains in order.
    set_in(2'd3, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("fill_count", 32'(q_count),  32'd4);
    chk("fill_pc",    32'(pc),       32'h0008);
    chk("fill_req",   32'(imem_req), 32'd0);
    chk("fill_npc",   32'(de_npc),   32'h0002);
    set_in(2'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("drain_count", 32'(q_count), 32'd0);

    // Branch redirect with three entries queued.
    set_in(2'd3, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("redir_pre_count", 32'(q_count), 32'd3);
    set_in(2'd1, 16'h3000, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("redir_count", 32'(q_count), 32'd0);
    chk("redir_pc",    32'(pc),      32'h3000);
    chk("redir_dev",   32'(de_v),    32'd0);
    tick();
    chk("redir_first_dev", 32'(de_v),   32'd1);
    chk("redir_first_ir",  32'(de_ir),  32'hCFFF);
    chk("redir_first_npc", 32'(de_npc), 32'h3002);
    tick();

    // Branch stall holds two queued entries, which issue after a fall-through resolve.
    set_in(2'd3, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("brst_count", 32'(q_count), 32'd2);
    set_in(2'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("brst_npc0", 32'(de_npc), 32'h0002);
    tick();
    chk("brst_npc1", 32'(de_npc), 32'h0004);
    tick();

    // Trap then reset-vector redirects back to back, imem ready throughout.
    set_in(2'd2, '0, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'd3, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("trap_pc",    32'(pc),      32'h0200);
    chk("trap_count", 32'(q_count), 32'd0);
    tick();
    chk("rv_pc",    32'(pc),      32'h0000);
    chk("rv_count", 32'(q_count), 32'd0);

    // Asynchronous reset mid-stream.
    set_in(2'd1, 16'h00FE, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_pre_pc",    32'(pc),      32'h0104);
    chk("mid_pre_count", 32'(q_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_pc",    32'(pc),       32'(RESET_PC));
    chk("mid_count", 32'(q_count),  32'd0);
    chk("mid_dev",   32'(de_v),     32'd0);
    chk("mid_req",   32'(imem_req), 32'd0);
    m_pc = RESET_PC;
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();

    // PC wraps at the top of the address space.
    set_in(2'd1, 16'hFFFE, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("wrap_pc",  32'(pc),     32'h0000);
    chk("wrap_dev", 32'(de_v),   32'd1);
    chk("wrap_npc", 32'(de_npc), 32'h0000);
    chk("wrap_ir",  32'(de_ir),  32'h0001);
    set_in(2'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Constrained-random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
             16'($urandom_range(0, 32767) * 2), 16'($urandom_range(0, 32767) * 2),
             $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised next-generation fetch stage. A PC register drives instruction memory, and accepted fetches are buffered in a DEPTH-entry prefetch queue in front of decode.
- Decode stalls no longer stall instruction memory until the queue fills.
- Handles sequential, branch-target, trap and reset-vector redirects, and flushes the queue on any redirect.
- Sits between imem and the decode latch and replaces the single-instruction fetch stage.

Parameters:
ADDR_W, 16, PC/address width in bits
INSTR_W, 16, instruction width in bits
DEPTH, 4, queue entries; power of two, >= 2
PC_INC, 2, sequential PC increment (bytes per instruction)
RESET_PC, 0, PC value after reset and for pcmux=3

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pcmux  in  2  redirect select: 0 = sequential, 1 = target_pc, 2 = trap_pc, 3 = RESET_PC
target_pc  in  ADDR_W  branch/jump target
trap_pc  in  ADDR_W  trap vector target
imem_addr  out  ADDR_W  fetch address; always equals pc
imem_req  out  1  fetch request this cycle
imem_r  in  1  imem ready; instr is valid this cycle
instr  in  INSTR_W  fetched instruction
br_stall  in  1  OR of the DE/AGEX/MEM branch-pending valids
dep_stall  in  1  decode dependency stall
mem_stall  in  1  memory-stage stall
de_v  out  1  head entry presented to decode is valid
de_ir  out  INSTR_W  head instruction; 0 when de_v=0
de_npc  out  ADDR_W  head entry's fetch PC + PC_INC; 0 when de_v=0
ld_de  out  1  decode latch load enable = !(dep_stall | mem_stall)
pc  out  ADDR_W  current fetch PC
q_count  out  clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Reset (asynchronous, any cycle, including mid-fetch or mid-redirect):
  - pc = RESET_PC, q_count = 0, head and tail pointers = 0.
  - Therefore de_v = 0, de_ir = 0, de_npc = 0 and imem_req = 0 while reset is high.
- redirect = (pcmux != 0). Redirect has priority over every other event.
  - Next edge: pc loads the selected target.
  - Next edge: queue flushed (q_count = 0, pointers = 0).
  - Any same-cycle fetch accept or decode pop is discarded.
- imem_req = !redirect & !br_stall & (q_count < DEPTH). Combinational.
- fetch accept = imem_req & imem_r.
  - Pushes {pc + PC_INC, instr} at the tail.
  - pc <= pc + PC_INC, wrapping mod 2^ADDR_W.
- No accept leaves pc unchanged: imem not ready, queue full, br_stall high, or redirect.
- Queue full blocks push even if a pop occurs the same cycle. No full-bypass; this keeps the imem_req path free of decode stall logic.
- de_v = (q_count != 0) & !br_stall & !redirect. Combinational from queue state.
  - de_ir and de_npc come from the head entry when de_v = 1, else 0.
- pop = de_v & ld_de. Head pointer advances at the next edge.
- Simultaneous push and pop (q_count strictly between 0 and DEPTH, no redirect): q_count unchanged and both pointers advance.
- Latency:
  - Instruction accepted in cycle N is first presentable at de_v in cycle N+1. There is no empty-queue bypass.
  - A redirect in cycle N gives imem_addr = target in cycle N+1 and imem_req may be high that cycle.
- br_stall:
  - Freezes fetch and hides the head.
  - Queued entries are retained; they are valid fall-through if the branch resolves with pcmux = 0.
  - They are discarded if the branch resolves with pcmux != 0.
- Pointer arithmetic wraps mod DEPTH. q_count never exceeds DEPTH or goes below 0; no overflow or underflow is possible by construction.
- ld_de is purely combinational and independent of queue state.

Test Plan:
- Reset release, imem_r=1, no stalls:
  - imem_addr sequence 0x0000, 0x0002, 0x0004 …
  - de_v rises one cycle after the first accept, with de_ir = instr fetched at 0x0000 and de_npc = 0x0002.
- dep_stall held high for 6 cycles with imem_r=1:
  - Queue fills to q_count = 4, then imem_req = 0 and pc holds at 0x0008.
  - After release, entries pop in order with de_npc = 0x0002, 0x0004, 0x0006, 0x0008.
- With 3 entries queued, pulse pcmux=1, target_pc=0x3000 for one cycle:
  - Next cycle q_count = 0, pc = 0x3000, de_v = 0.
  - The next decoded instruction is the one fetched at 0x3000.
- br_stall high for 3 cycles with 2 entries queued, then low with pcmux=0:
  - de_v = 0 and imem_req = 0 during the stall; q_count stays 2.
  - The same two entries issue afterwards.
- pcmux=2, trap_pc=0x0200, and pcmux=3 in consecutive cycles, each with imem_r=1:
  - pc = 0x0200, then RESET_PC. No push occurs in either cycle.
- Assert reset mid-stream with q_count = 3 and pc = 0x0104:
  - Immediately de_v = 0, imem_req = 0, q_count = 0.
  - pc = RESET_PC without waiting for a clock edge.
- ADDR_W=16, pc=0xFFFE accepted:
  - pc wraps to 0x0000 and the pushed de_npc = 0x0000.
